// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout window integrator.
package readout_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    // Constant-foldable ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed WIDTH-bit adder: clamps with an overflow flag when INTEGRATOR_SATURATE_EN
// is defined, otherwise wraps modulo 2^WIDTH.
module sat_add #(
    parameter int unsigned WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_sum
`ifdef INTEGRATOR_SATURATE_EN
    ,
    output logic                    o_ovf
`endif
);

`ifdef INTEGRATOR_SATURATE_EN
    logic [WIDTH:0] w_wide;

    assign w_wide = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
    // Overflow when the extra sign bit disagrees with the in-range sign bit.
    assign o_ovf  = w_wide[WIDTH] ^ w_wide[WIDTH-1];

    always_comb begin
        o_sum = w_wide[WIDTH-1:0];
        if (o_ovf) begin
            o_sum = w_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign o_sum = i_a + i_b;
`endif

endmodule

// File: rtl/readout_window_integrator.sv
// Integrates WINDOW accepted signed samples into one result with valid/ready on both sides.
// Define INTEGRATOR_SATURATE_EN for clamping additions and the o_out_sat flag.
module readout_window_integrator
    import readout_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned WINDOW     = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_in_valid,
    input  logic signed [DATA_WIDTH-1:0] i_in_data,
    output logic                         o_in_ready,
    output logic                         o_out_valid,
    output logic signed [ACC_WIDTH-1:0]  o_out_data,
    input  logic                         i_out_ready
`ifdef INTEGRATOR_SATURATE_EN
    ,
    output logic                         o_out_sat
`endif
);

    localparam int unsigned CNT_W = (clog2(WINDOW) > 0) ? clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    state_e                      r_state, w_state_next;
    logic [CNT_W-1:0]            r_count, w_count_next;
    logic signed [ACC_WIDTH-1:0] r_acc, w_acc_next;
    logic signed [ACC_WIDTH-1:0] r_out_data, w_out_data_next;
    logic signed [ACC_WIDTH-1:0] w_sample, w_sum;
    logic                        w_accept, w_release, w_last;

    assign o_out_valid = (r_state == StHold);
    assign o_in_ready  = ~o_out_valid | i_out_ready;
    assign o_out_data  = r_out_data;

    assign w_accept  = i_in_valid & o_in_ready;
    assign w_release = o_out_valid & i_out_ready;
    assign w_last    = (r_count == LAST);
    assign w_sample  = ACC_WIDTH'(i_in_data);

    // r_acc is already zero in HOLD, so an accept there starts the new window cleanly.
`ifdef INTEGRATOR_SATURATE_EN
    logic w_ovf;
    logic r_sat, w_sat_next;
    logic r_out_sat, w_out_sat_next;

    sat_add #(
        .WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_sample),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    assign o_out_sat = r_out_sat;

    always_comb begin
        w_sat_next     = r_sat;
        w_out_sat_next = r_out_sat;
        if (w_accept) begin
            if (w_last) begin
                w_out_sat_next = r_sat | w_ovf;
                w_sat_next     = 1'b0;
            end else begin
                w_sat_next = r_sat | w_ovf;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sat     <= 1'b0;
            r_out_sat <= 1'b0;
        end else begin
            r_sat     <= w_sat_next;
            r_out_sat <= w_out_sat_next;
        end
    end
`else
    sat_add #(
        .WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_sample),
        .o_sum (w_sum)
    );
`endif

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_acc_next      = r_acc;
        w_out_data_next = r_out_data;
        if (w_release) begin
            w_state_next = StIdle;
        end
        if (w_accept) begin
            if (w_last) begin
                w_state_next    = StHold;
                w_count_next    = '0;
                w_acc_next      = '0;
                w_out_data_next = w_sum;
            end else begin
                w_state_next = StAccum;
                w_count_next = r_count + 1'b1;
                w_acc_next   = w_sum;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_acc      <= w_acc_next;
            r_out_data <= w_out_data_next;
        end
    end

endmodule

// File: doc/readout_window_integrator.md
# readout_window_integrator

Accumulates a stream of signed readout samples over a fixed window of WINDOW accepted samples and emits one signed integrated value per window. It sits directly upstream of the signed threshold comparator in the cryo readout pipeline: out_data is the comparator's data_in_1 and the threshold is data_in_2. Valid/ready handshakes on both sides allow back-pressure from the discrimination stage.

## Interface
- DATA_WIDTH, 8, width of each signed input sample
- ACC_WIDTH, 16, width of the signed accumulator and of out_data; must be ≥ DATA_WIDTH
- WINDOW, 16, number of accepted samples per window; must be ≥ 1
- clk  input  1  the single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_data  input  DATA_WIDTH  signed sample
- in_ready  output  1  block accepts a sample this cycle
- out_valid  output  1  out_data holds a completed window sum
- out_data  output  ACC_WIDTH  signed integrated value
- out_ready  input  1  downstream consumes out_data this cycle
- out_sat  output  1  one or more additions in this window clamped; present only with the macro

## Operation
- States: IDLE (count=0, acc=0), ACCUM (0<count<WINDOW), HOLD (out_valid=1).
- Accept = in_valid & in_ready; in_ready = ~out_valid | out_ready.
- On accept: sample is sign-extended to ACC_WIDTH and added to acc; count increments. IDLE→ACCUM on the first accept (unless WINDOW=1).
- Accept with count=WINDOW-1: acc+sample is written to out_data, out_valid←1, acc←0, count←0, state→HOLD.
- HOLD: out_data is stable until out_valid & out_ready. On that handshake, out_valid←0 and state→IDLE, unless a sample is accepted in the same cycle. In that case the sample is the first of the new window (state→ACCUM, acc←sample), or a new result is loaded immediately when WINDOW=1.
- Width rule: with ACC_WIDTH ≥ DATA_WIDTH+clog2(WINDOW), no overflow can occur. Otherwise overflow behaviour is set by the macro.
- No accept while in_valid=0: state, acc and count hold. Gaps inside a window are allowed.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1 (cycle after rst), out_sat=0, acc=0, count=0, state IDLE.
- rst mid-window or in HOLD: partial sum and pending result are discarded, with no output.
- Latency: out_valid rises the cycle after the last sample of the window is accepted.
- Throughput: one sample per cycle with out_ready held high. No bubble between windows.
- in_ready is combinational from out_valid and out_ready only, never from in_valid.

## Configuration
- INTEGRATOR_SATURATE_EN defined:
  - Each addition clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - A sticky per-window flag is set on any clamp and is registered to out_sat with out_data.
  - The flag clears when a new window starts.
- Undefined:
  - Additions wrap modulo 2^ACC_WIDTH.
  - out_sat port and flag logic are absent.

## Structure
- Shared package readout_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD)
  - a count-width constant function clog2 used for count sizing
- One sub-module, sat_add: signed ACC_WIDTH adder.
  - With INTEGRATOR_SATURATE_EN: saturating, with an overflow output.
  - Without it: plain wrap.
- Counter, FSM and output register live in the top.

## Test plan
- DATA_WIDTH=8, ACC_WIDTH=12, WINDOW=4, out_ready=1, samples 10,-3,7,2 back-to-back → one cycle later out_valid=1, out_data=16, for exactly one cycle.
- Same config, out_ready=0 after window done, in_valid held high with samples 5,5,5,5 → in_ready=0 and out_data=16 stable. When out_ready goes to 1, the next window is accepted in that same cycle and yields 20.
- ACC_WIDTH=8, WINDOW=4, samples 100×4 → with INTEGRATOR_SATURATE_EN, out_data=127 and out_sat=1. Without it, out_data=-112.
- WINDOW=1, samples -128,127,0 streamed with out_ready=1 → out_data -128,127,0 on three consecutive cycles, each one cycle after its input.
- WINDOW=4, accept 3 samples, assert rst for one cycle, then feed 1,1,1,1 → out_data=4. No output is produced from the partial window.
- in_valid toggling 1,0,1,0,… for samples 1,2,3,4 → out_data=10. Sample gaps do not advance count.
